// File: rtl/bank_tally_scanner.sv
// Sweeps the counter bank read port and reduces it to max/argmax/sum/non-zero count.
// Ports: clk, rst, start in; datInR in (bank read data); addrR, busy, done, maxVal, maxAddr, sumVal, nzCount out.
module bank_tally_scanner #(
  parameter int BIT_ADDR = 4,
  parameter int BIT_DATO = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [BIT_DATO-1:0]          datInR,
  output logic [BIT_ADDR-1:0]          addrR,
  output logic                         busy,
  output logic                         done,
  output logic [BIT_DATO-1:0]          maxVal,
  output logic [BIT_ADDR-1:0]          maxAddr,
  output logic [BIT_DATO+BIT_ADDR-1:0] sumVal,
  output logic [BIT_ADDR:0]            nzCount
);

  localparam int SW = BIT_DATO + BIT_ADDR;
  localparam logic [BIT_ADDR-1:0] LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [BIT_ADDR-1:0] idx_q, idx_d;

  logic [BIT_DATO-1:0] accMax_q, accMax_d;
  logic [BIT_ADDR-1:0] accAddr_q, accAddr_d;
  logic [SW-1:0]       accSum_q, accSum_d;
  logic [BIT_ADDR:0]   accNz_q, accNz_d;

  logic [BIT_DATO-1:0] maxVal_q, maxVal_d;
  logic [BIT_ADDR-1:0] maxAddr_q, maxAddr_d;
  logic [SW-1:0]       sumVal_q, sumVal_d;
  logic [BIT_ADDR:0]   nzCount_q, nzCount_d;
  logic                done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      accMax_q  <= '0;
      accAddr_q <= '0;
      accSum_q  <= '0;
      accNz_q   <= '0;
      maxVal_q  <= '0;
      maxAddr_q <= '0;
      sumVal_q  <= '0;
      nzCount_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      accMax_q  <= accMax_d;
      accAddr_q <= accAddr_d;
      accSum_q  <= accSum_d;
      accNz_q   <= accNz_d;
      maxVal_q  <= maxVal_d;
      maxAddr_q <= maxAddr_d;
      sumVal_q  <= sumVal_d;
      nzCount_q <= nzCount_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    accMax_d  = accMax_q;
    accAddr_d = accAddr_q;
    accSum_d  = accSum_q;
    accNz_d   = accNz_q;
    maxVal_d  = maxVal_q;
    maxAddr_d = maxAddr_q;
    sumVal_d  = sumVal_q;
    nzCount_d = nzCount_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) begin
          state_d   = S_SCAN;
          accMax_d  = '0;
          accAddr_d = '0;
          accSum_d  = '0;
          accNz_d   = '0;
        end
      end
      S_SCAN: begin
        // strict compare keeps the lowest address on ties
        if (datInR > accMax_q) begin
          accMax_d  = datInR;
          accAddr_d = idx_q;
        end
        accSum_d = accSum_q + SW'(datInR);
        accNz_d  = accNz_q + {{BIT_ADDR{1'b0}}, |datInR};
        // natural wrap returns the read address to 0 for DONE
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        maxVal_d  = accMax_q;
        maxAddr_d = accAddr_q;
        sumVal_d  = accSum_q;
        nzCount_d = accNz_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign addrR   = idx_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign maxVal  = maxVal_q;
  assign maxAddr = maxAddr_q;
  assign sumVal  = sumVal_q;
  assign nzCount = nzCount_q;

endmodule

// File: tb/tb_bank_tally_scanner.sv
// Testbench for bank_tally_scanner: behavioural bank + reference reduction.
// Bank is modelled as an array read combinationally at addrR.
module tb_bank_tally_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] datInR;
  logic [3:0] addrR;
  logic       busy;
  logic       done;
  logic [2:0] maxVal;
  logic [3:0] maxAddr;
  logic [6:0] sumVal;
  logic [4:0] nzCount;

  logic [2:0] bank [16];
  logic [2:0] snap [16];

  logic [2:0] e_max;
  logic [3:0] e_addr;
  logic [6:0] e_sum;
  logic [4:0] e_nz;

  int n_pass = 0;
  int n_total = 0;

  bank_tally_scanner #(.BIT_ADDR(4), .BIT_DATO(3)) dut (
    .clk(clk), .rst(rst), .start(start), .datInR(datInR),
    .addrR(addrR), .busy(busy), .done(done), .maxVal(maxVal),
    .maxAddr(maxAddr), .sumVal(sumVal), .nzCount(nzCount)
  );

  always #5 clk = ~clk;

  assign datInR = bank[addrR];

  // reference: plain reduction over the values the sweep is expected to see
  function automatic void model();
    int mx, ma, s, nz;
    mx = 0; ma = 0; s = 0; nz = 0;
    for (int i = 0; i < 16; i++) begin
      if (int'(snap[i]) > mx) begin
        mx = int'(snap[i]);
        ma = i;
      end
      s += int'(snap[i]);
      if (snap[i] != 0) nz++;
    end
    e_max  = 3'(mx);
    e_addr = 4'(ma);
    e_sum  = 7'(s);
    e_nz   = 5'(nz);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_snap();
    for (int i = 0; i < 16; i++) snap[i] = bank[i];
  endtask

  // start pulse, returns edges from start edge to first done (-1 on timeout)
  task automatic run_sweep(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) bank[i] = 3'd0;
    tick();
    tick();
    n_total++;
    if ({busy, done, addrR, maxVal, maxAddr, sumVal, nzCount} !== 25'd0) begin
      $display("FAIL reset_state got busy=%b done=%b addr=%0d max=%0d maddr=%0d sum=%0d nz=%0d want all 0",
               busy, done, addrR, maxVal, maxAddr, sumVal, nzCount);
    end else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_all_zero();
    int first_done;
    logic busy16, busy17;
    for (int i = 0; i < 16; i++) bank[i] = 3'd0;
    set_snap();
    model();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL zero_busy_rise got %b want 1", busy);
    else n_pass++;
    first_done = -1;
    busy16 = 1'bx;
    busy17 = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 16) busy16 = busy;
      if (k == 17) busy17 = busy;
      if (done === 1'b1 && first_done < 0) first_done = k;
      if (k == 17) begin
        n_total++;
        if ({maxVal, maxAddr, sumVal, nzCount} !== {e_max, e_addr, e_sum, e_nz})
          $display("FAIL zero_results got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                   maxVal, maxAddr, sumVal, nzCount, e_max, e_addr, e_sum, e_nz);
        else n_pass++;
      end
      if (k == 18) begin
        n_total++;
        if (done !== 1'b0) $display("FAIL zero_done_pulse got %b want 0", done);
        else n_pass++;
      end
    end
    n_total++;
    if (first_done != 17) $display("FAIL zero_latency got %0d want 17", first_done);
    else n_pass++;
    n_total++;
    if ({busy16, busy17} !== 2'b10)
      $display("FAIL zero_busy_window got %b%b want 10", busy16, busy17);
    else n_pass++;
  endtask

  task automatic check_sweep(input string nm);
    int lat;
    set_snap();
    model();
    run_sweep(lat);
    n_total++;
    if (lat != 17) $display("FAIL %s_latency got %0d want 17", nm, lat);
    else n_pass++;
    n_total++;
    if ({maxVal, maxAddr} !== {e_max, e_addr})
      $display("FAIL %s_max got %0d@%0d want %0d@%0d", nm, maxVal, maxAddr, e_max, e_addr);
    else n_pass++;
    n_total++;
    if ({sumVal, nzCount} !== {e_sum, e_nz})
      $display("FAIL %s_sum_nz got %0d,%0d want %0d,%0d", nm, sumVal, nzCount, e_sum, e_nz);
    else n_pass++;
    tick();
  endtask

  task automatic test_tie();
    for (int i = 0; i < 16; i++) bank[i] = 3'd0;
    bank[3] = 3'd5;
    bank[9] = 3'd7;
    bank[12] = 3'd7;
    check_sweep("tie");
    n_total++;
    if ({maxVal, maxAddr, sumVal, nzCount} !== {3'd7, 4'd9, 7'd19, 5'd3})
      $display("FAIL tie_const got %0d/%0d/%0d/%0d want 7/9/19/3",
               maxVal, maxAddr, sumVal, nzCount);
    else n_pass++;
  endtask

  task automatic test_all_full();
    for (int i = 0; i < 16; i++) bank[i] = 3'd7;
    check_sweep("full");
    n_total++;
    if ({maxVal, maxAddr, sumVal, nzCount} !== {3'd7, 4'd0, 7'd112, 5'd16})
      $display("FAIL full_const got %0d/%0d/%0d/%0d want 7/0/112/16",
               maxVal, maxAddr, sumVal, nzCount);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) bank[i] = 3'd0;
        else bank[i] = 3'($urandom_range(0, 7));
      end
      check_sweep("rand");
    end
  endtask

  task automatic test_start_while_busy();
    logic [2:0] p_max;
    logic [3:0] p_addr;
    logic [6:0] p_sum;
    logic [4:0] p_nz;
    int ndone, first_done, held_bad;
    p_max = e_max; p_addr = e_addr; p_sum = e_sum; p_nz = e_nz;
    for (int i = 0; i < 16; i++) bank[i] = 3'(i % 5);
    set_snap();
    model();
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    first_done = -1;
    held_bad = 0;
    for (int k = 1; k <= 45; k++) begin
      start = (k == 3 || k == 10) ? 1'b1 : 1'b0;
      tick();
      if (k <= 16 &&
          {maxVal, maxAddr, sumVal, nzCount} !== {p_max, p_addr, p_sum, p_nz})
        held_bad++;
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
    end
    start = 1'b0;
    n_total++;
    if (held_bad != 0) $display("FAIL busy_hold got %0d changed cycles want 0", held_bad);
    else n_pass++;
    n_total++;
    if (ndone != 1 || first_done != 17)
      $display("FAIL busy_ignore got %0d done at %0d want 1 at 17", ndone, first_done);
    else n_pass++;
    n_total++;
    if ({maxVal, maxAddr, sumVal, nzCount} !== {e_max, e_addr, e_sum, e_nz})
      $display("FAIL busy_results got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               maxVal, maxAddr, sumVal, nzCount, e_max, e_addr, e_sum, e_nz);
    else n_pass++;
  endtask

  task automatic test_addr_and_writes();
    int addr_bad;
    for (int i = 0; i < 16; i++) bank[i] = 3'($urandom_range(0, 7));
    bank[2] = 3'd3;
    set_snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    addr_bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (addrR !== 4'(k)) addr_bad++;
      if (k == 1) begin
        bank[2] = bank[2] + 3'd1;
        snap[2] = bank[2];
      end
      if (k == 4) bank[2] = bank[2] + 3'd1;
      tick();
    end
    n_total++;
    if (addr_bad != 0) $display("FAIL addr_seq got %0d bad steps want 0", addr_bad);
    else n_pass++;
    n_total++;
    if (addrR !== 4'd0) $display("FAIL addr_done got %0d want 0", addrR);
    else n_pass++;
    model();
    tick();
    n_total++;
    if (done !== 1'b1) $display("FAIL wr_done got %b want 1", done);
    else n_pass++;
    n_total++;
    if ({maxVal, maxAddr, sumVal, nzCount} !== {e_max, e_addr, e_sum, e_nz})
      $display("FAIL wr_results got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               maxVal, maxAddr, sumVal, nzCount, e_max, e_addr, e_sum, e_nz);
    else n_pass++;
    tick();
  endtask

  task automatic test_mid_reset();
    int ndone;
    for (int i = 0; i < 16; i++) bank[i] = 3'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    n_total++;
    if (addrR !== 4'd5) $display("FAIL mid_pre_addr got %0d want 5", addrR);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if ({busy, done, addrR, maxVal, maxAddr, sumVal, nzCount} !== 25'd0)
      $display("FAIL mid_reset got busy=%b addr=%0d max=%0d maddr=%0d sum=%0d nz=%0d want all 0",
               busy, addrR, maxVal, maxAddr, sumVal, nzCount);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) ndone++;
    end
    n_total++;
    if (ndone != 0) $display("FAIL mid_no_done got %0d active cycles want 0", ndone);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0, d1;
    for (int i = 0; i < 16; i++) bank[i] = 3'($urandom_range(0, 7));
    d0 = -1;
    d1 = -1;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (done === 1'b1) begin
        if (d0 < 0) d0 = k;
        else if (d1 < 0) d1 = k;
      end
    end
    start = 1'b0;
    n_total++;
    if (d0 != 17 || d1 - d0 != 18)
      $display("FAIL retrigger got first=%0d period=%0d want 17 and 18", d0, d1 - d0);
    else n_pass++;
    for (int k = 0; k < 25; k++) tick();
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_tie();
    test_all_full();
    test_random();
    test_start_while_busy();
    test_addr_and_writes();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
